// File: rtl/interconn_rr_sched_pkg.sv
// Shared types and default sizing for the round-robin MVU crossbar.
package interconn_pkg;

  localparam int N_MVU   = 8;
  localparam int W_DATA  = 64;
  localparam int BADDR_W = 15;
  localparam int IDW     = $clog2(N_MVU);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } src_state_t;

  function automatic int next_idx(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/interconn_rr_sched_if.sv
// Source-side send handshake and destination-side write port of the crossbar.
interface interconn_if
  import interconn_pkg::*;
#(
  parameter int N     = N_MVU,
  parameter int W     = W_DATA,
  parameter int BADDR = BADDR_W
);

  logic [N-1:0]                send_req;
  logic [N-1:0][N-1:0]         send_to;
  logic [N-1:0][BADDR-1:0]     send_addr;
  logic [N-1:0][W-1:0]         send_word;
  logic [N-1:0]                send_rdy;
  logic [N-1:0]                send_ack;
  logic [N-1:0]                dst_rdy;
  logic [N-1:0]                recv_en;
  logic [N-1:0][N-1:0]         recv_from;
  logic [N-1:0][BADDR-1:0]     recv_addr;
  logic [N-1:0][W-1:0]         recv_word;

  modport master (
    output send_req, send_to, send_addr, send_word, dst_rdy,
    input  send_rdy, send_ack, recv_en, recv_from, recv_addr, recv_word
  );

  modport slave (
    input  send_req, send_to, send_addr, send_word, dst_rdy,
    output send_rdy, send_ack, recv_en, recv_from, recv_addr, recv_word
  );

endinterface

// File: rtl/interconn_rr_sched_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import interconn_pkg::*;
#(
  parameter int N  = N_MVU,
  parameter int IW = IDW
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  always_comb begin : arb
    int idx;
    // NOTE: every output gets a default before the search loop, so no latch is inferred.
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/interconn_rr_sched.sv
// Fair MVU crossbar: per-source IDLE/BUSY/ACK FSM, per-destination round-robin
// arbiter, registered write ports and a single ack per (multicast) transfer.
module interconn_rr_sched
  import interconn_pkg::*;
#(
  parameter int N     = N_MVU,
  parameter int W     = W_DATA,
  parameter int BADDR = BADDR_W
) (
  input logic        clk,
  input logic        clr_n,
  interconn_if.slave bus
);

  localparam int IW = $clog2(N);

  src_state_t       r_state     [N];
  src_state_t       w_state_nxt [N];
  logic [N-1:0]     r_pend      [N];
  logic [N-1:0]     w_pend_nxt  [N];
  logic [BADDR-1:0] r_addr      [N];
  logic [W-1:0]     r_word      [N];
  logic [IW-1:0]    r_ptr       [N];

  logic [N-1:0]     w_req       [N];
  logic [N-1:0]     w_gnt       [N];
  logic [IW-1:0]    w_gid       [N];
  logic [N-1:0]     w_clr       [N];
  logic [N-1:0]     w_any;
  logic [N-1:0]     w_accept;

  logic [N-1:0]            r_recv_en;
  logic [N-1:0][N-1:0]     r_recv_from;
  logic [N-1:0][BADDR-1:0] r_recv_addr;
  logic [N-1:0][W-1:0]     r_recv_word;

  // w_req is indexed [dest][src]; w_clr is its grant-side transpose [src][dest].
  for (genvar j = 0; j < N; j++) begin : g_xbar
    for (genvar i = 0; i < N; i++) begin : g_src
      assign w_req[j][i] = (r_state[i] == BUSY) & r_pend[i][j];
      assign w_clr[i][j] = w_gnt[j][i];
    end

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
      .req    (w_req[j]),
      .en     (bus.dst_rdy[j]),
      .ptr    (r_ptr[j]),
      .gnt    (w_gnt[j]),
      .gnt_id (w_gid[j]),
      .any    (w_any[j])
    );
  end

  for (genvar i = 0; i < N; i++) begin : g_flags
    assign w_accept[i]     = (r_state[i] == IDLE) & bus.send_req[i];
    assign bus.send_rdy[i] = (r_state[i] == IDLE);
    assign bus.send_ack[i] = (r_state[i] == ACK);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      w_pend_nxt[i]  = r_pend[i];
      unique case (r_state[i])
        IDLE: begin
          if (bus.send_req[i]) begin
            w_pend_nxt[i]  = bus.send_to[i];
            w_state_nxt[i] = (bus.send_to[i] != '0) ? BUSY : ACK;
          end
        end
        BUSY: begin
          w_pend_nxt[i] = r_pend[i] & ~w_clr[i];
          if (w_pend_nxt[i] == '0) w_state_nxt[i] = ACK;
        end
        ACK:     w_state_nxt[i] = IDLE;
        default: w_state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!clr_n) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= IDLE;
        r_pend[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_pend[i]  <= w_pend_nxt[i];
      end
    end
  end

  // NOTE: the per-source payload buffers are reset so a fresh run never exposes stale data.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < N; i++) begin
        r_addr[i] <= '0;
        r_word[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_accept[i]) begin
          r_addr[i] <= bus.send_addr[i];
          r_word[i] <= bus.send_word[i];
        end
      end
    end
  end

  // Write port payload holds its last value while recv_en is low.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_recv_en   <= '0;
      r_recv_from <= '0;
      r_recv_addr <= '0;
      r_recv_word <= '0;
      for (int j = 0; j < N; j++) r_ptr[j] <= '0;
    end else begin
      r_recv_en <= w_any;
      for (int j = 0; j < N; j++) begin
        if (w_any[j]) begin
          r_ptr[j]       <= IW'(next_idx(int'(w_gid[j]), N));
          r_recv_from[j] <= w_gnt[j];
          r_recv_addr[j] <= r_addr[w_gid[j]];
          r_recv_word[j] <= r_word[w_gid[j]];
        end
      end
    end
  end

  assign bus.recv_en   = r_recv_en;
  assign bus.recv_from = r_recv_from;
  assign bus.recv_addr = r_recv_addr;
  assign bus.recv_word = r_recv_word;

endmodule

// File: tb/tb_interconn_rr_sched.sv
// Bench for interconn_rr_sched: vector table plus per-destination delivery scoreboard.
module tb_interconn_rr_sched;

  localparam int N     = 8;
  localparam int W     = 64;
  localparam int BADDR = 15;

  typedef struct {
    int               src;
    logic [N-1:0]     mask;
    logic [BADDR-1:0] addr;
    logic [W-1:0]     word;
    logic [N-1:0]     hold_mask;
    int               hold_len;
    int               exp_ack;
    logic [N-1:0]     exp_en;
  } vec_t;

  typedef struct {
    logic [N-1:0]     from;
    logic [BADDR-1:0] addr;
    logic [W-1:0]     word;
  } dlv_t;

  logic clk;
  logic clr_n;
  int   n_vec = 0;
  int   n_err = 0;
  dlv_t exp_q [N][$];
  dlv_t got_e;
  vec_t vecs  [6];

  interconn_if #(.N(N), .W(W), .BADDR(BADDR)) bus ();

  interconn_rr_sched #(.N(N), .W(W), .BADDR(BADDR)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pending_count();
    int s = 0;
    for (int j = 0; j < N; j++) s += exp_q[j].size();
    return s;
  endfunction

  task automatic push_exp(input int src, input logic [N-1:0] mask,
                          input logic [BADDR-1:0] addr, input logic [W-1:0] word);
    dlv_t d;
    d.from = N'(1) << src;
    d.addr = addr;
    d.word = word;
    for (int j = 0; j < N; j++) if (mask[j]) exp_q[j].push_back(d);
  endtask

  // Scoreboard: every delivery must match the oldest outstanding expectation for its destination.
  always @(negedge clk) begin
    if (clr_n) begin
      for (int j = 0; j < N; j++) begin
        if (bus.recv_en[j]) begin
          if (exp_q[j].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_recv dest %0d: got from=%0h, required no delivery", j, bus.recv_from[j]);
          end else begin
            got_e = exp_q[j].pop_front();
            check($sformatf("recv_from[%0d]", j), 64'(bus.recv_from[j]), 64'(got_e.from));
            check($sformatf("recv_addr[%0d]", j), 64'(bus.recv_addr[j]), 64'(got_e.addr));
            check($sformatf("recv_word[%0d]", j), bus.recv_word[j], got_e.word);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.send_req  = '0;
    bus.send_to   = '0;
    bus.send_addr = '0;
    bus.send_word = '0;
    bus.dst_rdy   = '1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    idle_inputs();
    for (int j = 0; j < N; j++) exp_q[j].delete();
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int ack_k;
    @(negedge clk);
    check("rdy_before", 64'(bus.send_rdy[v.src]), 64'd1);
    bus.send_req[v.src]  = 1'b1;
    bus.send_to[v.src]   = v.mask;
    bus.send_addr[v.src] = v.addr;
    bus.send_word[v.src] = v.word;
    bus.dst_rdy          = ~v.hold_mask;
    @(posedge clk);
    push_exp(v.src, v.mask, v.addr, v.word);
    ack_k = -1;
    for (int k = 1; k <= 40 && ack_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.send_req[v.src] = 1'b0;
      if (bus.send_ack[v.src]) begin
        ack_k = k;
        check("en_at_ack", 64'(bus.recv_en), 64'(v.exp_en));
      end
      if (k == v.hold_len) bus.dst_rdy = '1;
    end
    check("ack_latency", 64'(ack_k), 64'(v.exp_ack));
    @(negedge clk);
    check("ack_pulse", 64'(bus.send_ack[v.src]), 64'd0);
    check("rdy_after", 64'(bus.send_rdy[v.src]), 64'd1);
    check("sb_drained", 64'(pending_count()), 64'd0);
  endtask

  // Three sources unicast to one destination; s0,s1,s2 is the required grant order.
  task automatic contend(input int s0, input int s1, input int s2, input logic [N-1:0] dst);
    int ord [3];
    int ack_k [3];
    ord = '{s0, s1, s2};
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      bus.send_req[ord[n]]  = 1'b1;
      bus.send_to[ord[n]]   = dst;
      bus.send_addr[ord[n]] = BADDR'(15'h100 + ord[n]);
      bus.send_word[ord[n]] = 64'hC0DE_0000 + 64'(ord[n]);
    end
    bus.dst_rdy = '1;
    @(posedge clk);
    for (int n = 0; n < 3; n++)
      push_exp(ord[n], dst, BADDR'(15'h100 + ord[n]), 64'hC0DE_0000 + 64'(ord[n]));
    ack_k = '{-1, -1, -1};
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.send_req = '0;
      for (int n = 0; n < 3; n++)
        if (ack_k[n] < 0 && bus.send_ack[ord[n]]) ack_k[n] = k;
    end
    for (int n = 0; n < 3; n++)
      check($sformatf("contend_ack_src%0d", ord[n]), 64'(ack_k[n]), 64'(n + 2));
    check("contend_drained", 64'(pending_count()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{src: 2, mask: 8'h20, addr: 15'h123,  word: 64'hDEADBEEF,
                hold_mask: 8'h00, hold_len: 0, exp_ack: 2, exp_en: 8'h20};
    vecs[1] = '{src: 1, mask: 8'hFF, addr: 15'h7FFF, word: 64'hFFFF_0000_A5A5_1234,
                hold_mask: 8'h00, hold_len: 0, exp_ack: 2, exp_en: 8'hFF};
    vecs[2] = '{src: 0, mask: 8'h41, addr: 15'h0042, word: 64'h0123_4567_89AB_CDEF,
                hold_mask: 8'h40, hold_len: 5, exp_ack: 6, exp_en: 8'h40};
    vecs[3] = '{src: 3, mask: 8'h00, addr: 15'h0555, word: 64'h1111_2222,
                hold_mask: 8'h00, hold_len: 0, exp_ack: 1, exp_en: 8'h00};
    vecs[4] = '{src: 7, mask: 8'h80, addr: 15'h0001, word: 64'h8000_0000_0000_0001,
                hold_mask: 8'h00, hold_len: 0, exp_ack: 2, exp_en: 8'h80};
    vecs[5] = '{src: 6, mask: 8'h03, addr: 15'h2AAA, word: 64'h5555_AAAA_5555_AAAA,
                hold_mask: 8'h00, hold_len: 0, exp_ack: 2, exp_en: 8'h03};

    clr_n = 1'b0;
    idle_inputs();
    #12;
    check("reset_send_rdy", 64'(bus.send_rdy), 64'hFF);
    check("reset_send_ack", 64'(bus.send_ack), 64'h0);
    check("reset_recv_en",  64'(bus.recv_en),  64'h0);
    check("reset_recv_from", bus.recv_from, 64'h0);
    do_reset();

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Fresh pointers: 0,1,3 in index order; ptr[4] ends at 4, so the next round starts at 5.
    do_reset();
    contend(0, 1, 3, 8'h10);
    contend(5, 2, 3, 8'h10);

    // Abort a transfer stuck in BUSY with an asynchronous reset between edges.
    @(negedge clk);
    bus.send_req[4]  = 1'b1;
    bus.send_to[4]   = 8'h08;
    bus.send_addr[4] = 15'h0777;
    bus.send_word[4] = 64'hBAD0_BAD0;
    bus.dst_rdy      = ~8'h08;
    @(posedge clk);
    @(negedge clk);
    bus.send_req = '0;
    check("busy_not_rdy", 64'(bus.send_rdy[4]), 64'd0);
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("async_send_rdy",  64'(bus.send_rdy), 64'hFF);
    check("async_send_ack",  64'(bus.send_ack), 64'h0);
    check("async_recv_en",   64'(bus.recv_en),  64'h0);
    check("async_recv_from", bus.recv_from, 64'h0);
    check("async_recv_addr", 64'(|bus.recv_addr), 64'h0);
    check("async_recv_word", 64'(|bus.recv_word), 64'h0);
    for (int j = 0; j < N; j++) exp_q[j].delete();
    @(negedge clk);
    clr_n = 1'b1;
    bus.dst_rdy = '1;
    run_vec(vecs[0]);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
